// File: rtl/aidan_mcnay_trial_div_ctrl.sv
// Trial-division primality sequencer: walks divisors 2,3,(5,7..) against a latched operand through an
// external divider, stopping once d*d exceeds the operand. Define AIDAN_MCNAY_TRIAL_DIV_COUNT_EN for resp_div_count.
module aidan_mcnay_trial_div_ctrl #(
    parameter int nbits     = 16,
    parameter bit SKIP_EVEN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [nbits-1:0] req_value,
    output logic             div_req_val,
    input  logic             div_req_rdy,
    output logic [nbits-1:0] div_dividend,
    output logic [nbits-1:0] div_divisor,
    input  logic             div_resp_val,
    output logic             div_resp_rdy,
    input  logic [nbits-1:0] div_remainder,
    output logic             resp_val,
    input  logic             resp_rdy,
`ifdef AIDAN_MCNAY_TRIAL_DIV_COUNT_EN
    output logic [nbits-1:0] resp_div_count,
`endif
    output logic             resp_is_prime,
    output logic [nbits-1:0] resp_factor
);
    localparam int SQW = 2 * nbits;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CHECK    = 3'd1;
    localparam logic [2:0] DIV_REQ  = 3'd2;
    localparam logic [2:0] DIV_RESP = 3'd3;
    localparam logic [2:0] NEXT     = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [nbits-1:0] val_q, val_d;
    logic [nbits-1:0] d_q, d_d;
    logic [SQW-1:0]   sq_q, sq_d;
    logic             is_prime_q, is_prime_d;
    logic [nbits-1:0] factor_q, factor_d;

    logic [SQW-1:0] d_ext, val_ext;
    assign d_ext   = {{nbits{1'b0}}, d_q};
    assign val_ext = {{nbits{1'b0}}, val_q};

    always_comb begin
        state_d    = state_q;
        val_d      = val_q;
        d_d        = d_q;
        sq_d       = sq_q;
        is_prime_d = is_prime_q;
        factor_d   = factor_q;
        case (state_q)
            IDLE: begin
                if (req_val) begin
                    val_d      = req_value;
                    d_d        = nbits'(2);
                    sq_d       = SQW'(4);
                    is_prime_d = 1'b0;
                    factor_d   = '0;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (val_q < nbits'(2)) begin
                    is_prime_d = 1'b0;
                    factor_d   = '0;
                    state_d    = DONE;
                end else if (sq_q > val_ext) begin
                    is_prime_d = 1'b1;
                    factor_d   = '0;
                    state_d    = DONE;
                end else begin
                    state_d = DIV_REQ;
                end
            end
            DIV_REQ: begin
                if (div_req_rdy) state_d = DIV_RESP;
            end
            DIV_RESP: begin
                if (div_resp_val) begin
                    if (div_remainder == '0) begin
                        is_prime_d = 1'b0;
                        factor_d   = d_q;
                        state_d    = DONE;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            NEXT: begin
                // (d+k)^2 = d^2 + 2kd + k^2, so the square tracks d without a multiplier
                if (d_q == nbits'(2)) begin
                    d_d  = nbits'(3);
                    sq_d = SQW'(9);
                end else if (SKIP_EVEN) begin
                    d_d  = d_q + nbits'(2);
                    sq_d = sq_q + (d_ext << 2) + SQW'(4);
                end else begin
                    d_d  = d_q + nbits'(1);
                    sq_d = sq_q + (d_ext << 1) + SQW'(1);
                end
                state_d = CHECK;
            end
            DONE: begin
                if (resp_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            val_q      <= '0;
            d_q        <= '0;
            sq_q       <= '0;
            is_prime_q <= 1'b0;
            factor_q   <= '0;
        end else begin
            state_q    <= state_d;
            val_q      <= val_d;
            d_q        <= d_d;
            sq_q       <= sq_d;
            is_prime_q <= is_prime_d;
            factor_q   <= factor_d;
        end
    end

`ifdef AIDAN_MCNAY_TRIAL_DIV_COUNT_EN
    logic [nbits-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE && req_val)
            cnt_d = '0;
        else if (state_q == DIV_RESP && div_resp_val && !(&cnt_q))
            cnt_d = cnt_q + nbits'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign resp_div_count = cnt_q;
`endif

    assign req_rdy       = (state_q == IDLE);
    assign div_req_val   = (state_q == DIV_REQ);
    assign div_resp_rdy  = (state_q == DIV_RESP);
    assign resp_val      = (state_q == DONE);
    assign div_dividend  = val_q;
    assign div_divisor   = d_q;
    assign resp_is_prime = is_prime_q;
    assign resp_factor   = factor_q;

endmodule

// File: tb/tb_aidan_mcnay_trial_div_ctrl.sv
// Directed bench for aidan_mcnay_trial_div_ctrl: the bench acts as requester, divider and consumer,
// computing remainders itself and checking results, divisor order, stalls and reset abort.
module tb_aidan_mcnay_trial_div_ctrl;
    localparam int NB   = 16;
    localparam bit SKIP = 1'b1;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_val, req_rdy;
    logic [NB-1:0] req_value;
    logic          div_req_val, div_req_rdy;
    logic [NB-1:0] div_dividend, div_divisor;
    logic          div_resp_val, div_resp_rdy;
    logic [NB-1:0] div_remainder;
    logic          resp_val, resp_rdy, resp_is_prime;
    logic [NB-1:0] resp_factor;
`ifdef AIDAN_MCNAY_TRIAL_DIV_COUNT_EN
    logic [NB-1:0] resp_div_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aidan_mcnay_trial_div_ctrl #(.nbits(NB), .SKIP_EVEN(SKIP)) dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy), .req_value(req_value),
        .div_req_val(div_req_val), .div_req_rdy(div_req_rdy),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_resp_val(div_resp_val), .div_resp_rdy(div_resp_rdy),
        .div_remainder(div_remainder),
        .resp_val(resp_val), .resp_rdy(resp_rdy),
`ifdef AIDAN_MCNAY_TRIAL_DIV_COUNT_EN
        .resp_div_count(resp_div_count),
`endif
        .resp_is_prime(resp_is_prime), .resp_factor(resp_factor)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_div(input int k);
        if (SKIP) return (k == 0) ? 2 : 2 * k + 1;
        return k + 2;
    endfunction

    // One operand end to end; exp_lat < 0 skips the latency check.
    task automatic run_op(input logic [NB-1:0] v, input logic exp_prime, input logic [NB-1:0] exp_fac,
                          input int exp_cnt, input int rq_stall, input int rs_stall,
                          input int out_stall, input int exp_lat);
        int nreq = 0, stall = 0, lat = 0;
        logic pending = 1'b0;
        logic [NB-1:0] rem = '0, held_div = '0;
        bit done = 0, dup = 0, unstable = 0, bad_div = 0;
        logic held_prime;
        logic [NB-1:0] held_fac;
        for (int i = 0; i < 20 && !req_rdy; i++) @(negedge clk);
        check("req_rdy_before_accept", req_rdy, 1);
        req_val = 1'b1;
        req_value = v;
        @(negedge clk);
        req_val = 1'b0;
        for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            lat++;
            div_req_rdy = 1'b0;
            div_resp_val = 1'b0;
            if (resp_val) begin
                done = 1;
            end else if (div_req_val) begin
                if (pending) dup = 1;
                if (stall == 0) held_div = div_divisor;
                else if (div_divisor !== held_div || div_dividend !== v) unstable = 1;
                if (stall < rq_stall) begin
                    stall++;
                end else begin
                    div_req_rdy = 1'b1;
                    stall = 0;
                    if (div_divisor !== NB'(exp_div(nreq))) bad_div = 1;
                    rem = v % div_divisor;
                    nreq++;
                    pending = 1'b1;
                end
            end else if (pending && div_resp_rdy) begin
                if (stall < rs_stall) begin
                    stall++;
                end else begin
                    div_resp_val = 1'b1;
                    div_remainder = rem;
                    stall = 0;
                    pending = 1'b0;
                end
            end
        end
        check("resp_timeout", done, 1);
        if (exp_lat >= 0) check("latency", lat, exp_lat);
        held_prime = resp_is_prime;
        held_fac = resp_factor;
        for (int i = 0; i < out_stall; i++) begin
            @(negedge clk);
            check("resp_val_held", resp_val, 1);
            check("prime_held", resp_is_prime, held_prime);
            check("factor_held", resp_factor, held_fac);
        end
        check("is_prime", resp_is_prime, exp_prime);
        check("factor", resp_factor, exp_fac);
        check("div_count", nreq, exp_cnt);
        check("divisor_order", bad_div, 0);
        check("dup_request", dup, 0);
        check("req_stable", unstable, 0);
`ifdef AIDAN_MCNAY_TRIAL_DIV_COUNT_EN
        check("resp_div_count", resp_div_count, exp_cnt);
`endif
        $display("op value=%0d prime=%0d factor=%0d divisions=%0d latency=%0d",
                 v, resp_is_prime, resp_factor, nreq, lat);
        resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;
        check("resp_val_after_ack", resp_val, 0);
        check("req_rdy_after_ack", req_rdy, 1);
    endtask

    initial begin
        int nresp;
        reset = 1'b1;
        req_val = 1'b0; req_value = '0;
        div_req_rdy = 1'b0; div_resp_val = 1'b0; div_remainder = '0;
        resp_rdy = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_rdy", req_rdy, 1);
        check("rst_div_req_val", div_req_val, 0);
        check("rst_div_resp_rdy", div_resp_rdy, 0);
        check("rst_resp_val", resp_val, 0);
        check("rst_is_prime", resp_is_prime, 0);
        check("rst_factor", resp_factor, 0);

        run_op(16'd0, 1'b0, 16'd0, 0, 0, 0, 0, 2);
        run_op(16'd1, 1'b0, 16'd0, 0, 0, 0, 0, 2);
        run_op(16'd2, 1'b1, 16'd0, 0, 0, 0, 0, 2);
        run_op(16'd3, 1'b1, 16'd0, 0, 0, 0, 0, 2);
        run_op(16'd9, 1'b0, 16'd3, 2, 0, 0, 0, -1);
        run_op(16'd91, 1'b0, 16'd7, SKIP ? 4 : 6, 0, 0, 0, -1);
        run_op(16'd97, 1'b1, 16'd0, SKIP ? 5 : 8, 0, 1, 0, -1);
        run_op(16'd65521, 1'b1, 16'd0, SKIP ? 128 : 254, 0, 0, 0, -1);
        run_op(16'd221, 1'b0, 16'd13, SKIP ? 7 : 12, 5, 7, 4, -1);

        // Abort 65521 while the controller waits on the divider.
        req_val = 1'b1; req_value = 16'd65521;
        @(negedge clk);
        req_val = 1'b0;
        nresp = 0;
        for (int cyc = 0; cyc < 100 && !(nresp >= 3 && div_resp_rdy); cyc++) begin
            div_req_rdy = 1'b0;
            div_resp_val = 1'b0;
            if (div_req_val) begin
                div_req_rdy = 1'b1;
                div_remainder = req_value % div_divisor;
            end else if (div_resp_rdy) begin
                div_resp_val = 1'b1;
                nresp++;
            end
            @(negedge clk);
        end
        div_req_rdy = 1'b0;
        div_resp_val = 1'b0;
        check("abort_in_div_resp", div_resp_rdy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_req_rdy", req_rdy, 1);
        check("abort_resp_val", resp_val, 0);
        check("abort_div_resp_rdy", div_resp_rdy, 0);
        div_resp_val = 1'b1;
        div_remainder = '0;
        @(negedge clk);
        div_resp_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("abort_stay_idle", {resp_val, div_req_val, req_rdy}, 3'b001);
            @(negedge clk);
        end
        $display("op abort value=65521 after %0d divisions", nresp);

        run_op(16'd15, 1'b0, 16'd3, 2, 0, 0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
